// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access widths,
// and the lane-mask helpers used by both the control path and the lane aligner.
package lsu_pkg;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FIRST  = 2'b01,
        SECOND = 2'b10,
        DONE   = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } width_e;

    // Contiguous lane mask for an access width, anchored at lane 0.
    function automatic logic [3:0] width_mask(input width_e width);
        case (width)
            BYTE:    width_mask = 4'b0001;
            HALF:    width_mask = 4'b0011;
            default: width_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane steering: byte enables and write data for both beats of a
// possibly misaligned access, and right-aligned extraction of each beat's read lanes.
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  width,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        split,
    output logic [3:0]  be_first,
    output logic [3:0]  be_second,
    output logic [31:0] wdata_first,
    output logic [31:0] wdata_second,
    output logic [31:0] rdata_first,
    output logic [31:0] rdata_second
);

    logic [3:0]  access_mask;
    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [31:0] data_mask;
    logic [4:0]  lo_shift;
    logic [5:0]  hi_shift;

    // Shifting across an 8-lane / 64-bit window yields both beats at once:
    // the low half is the first beat, the overflow is the second.
    assign access_mask = width_mask(width_e'(width));
    assign be_wide     = {4'b0000, access_mask} << offset;
    assign wdata_wide  = {32'h0, wdata} << {offset, 3'b000};
    assign data_mask   = lane_mask(access_mask);
    assign lo_shift    = {offset, 3'b000};
    assign hi_shift    = 6'd32 - {1'b0, offset, 3'b000};

    assign split        = |be_wide[7:4];
    assign be_first     = be_wide[3:0];
    assign be_second    = be_wide[7:4];
    assign wdata_first  = wdata_wide[31:0];
    assign wdata_second = wdata_wide[63:32];

    // Second-beat lanes land just above the bytes the first beat supplied.
    assign rdata_first  = (rdata >> lo_shift) & data_mask;
    assign rdata_second = (rdata << hi_shift) & data_mask;

endmodule

// File: rtl/load_store_unit.sv
// CPU-facing load/store unit: turns byte/half/word accesses at any byte offset
// into one or two word-bus beats, with per-beat ack timeout and fault reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_fault,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  width_q, width_d;
    logic [31:0] wdata_q, wdata_d;
    logic        load_q, load_d;

    logic        idle;
    logic        request;
    logic        bad_request;
    logic        to_done;
    logic [1:0]  al_offset;
    logic [1:0]  al_width;
    logic [31:0] al_wdata;
    logic        al_split;
    logic [3:0]  al_be_first, al_be_second;
    logic [31:0] al_wdata_first, al_wdata_second;
    logic [31:0] al_rdata_first, al_rdata_second;
    logic        unused_sign_bit;

    // funct3[2] only selects sign extension, which the CPU performs itself.
    assign unused_sign_bit = i_funct3[2];

    assign idle        = (state_q == IDLE);
    assign request     = i_load | i_write;
    assign bad_request = (i_funct3[1:0] == 2'b11) | (i_load & i_write);

    // In IDLE the aligner sees the live request so the first beat can be
    // registered on acceptance; afterwards it works from the latched copy.
    assign al_offset = idle ? i_addr[1:0]   : off_q;
    assign al_width  = idle ? i_funct3[1:0] : width_q;
    assign al_wdata  = idle ? i_wdata       : wdata_q;

    byte_lane_align u_align (
        .offset       (al_offset),
        .width        (al_width),
        .wdata        (al_wdata),
        .rdata        (i_bus_rdata),
        .split        (al_split),
        .be_first     (al_be_first),
        .be_second    (al_be_second),
        .wdata_first  (al_wdata_first),
        .wdata_second (al_wdata_second),
        .rdata_first  (al_rdata_first),
        .rdata_second (al_rdata_second)
    );

    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        fault_d     = 1'b0;
        off_d       = off_q;
        width_d     = width_q;
        wdata_d     = wdata_q;
        load_d      = load_q;
        to_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (request) begin
                    off_d   = i_addr[1:0];
                    width_d = i_funct3[1:0];
                    wdata_d = i_wdata;
                    load_d  = i_load;
                    rdata_d = 32'h0;
                    cnt_d   = 8'h00;
                    if (bad_request) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = FIRST;
                        bus_req_d   = 1'b1;
                        bus_we_d    = i_write;
                        bus_addr_d  = {i_addr[31:2], 2'b00};
                        bus_be_d    = al_be_first;
                        bus_wdata_d = al_wdata_first;
                    end
                end
            end

            FIRST, SECOND: begin
                if (i_bus_ack) begin
                    cnt_d = 8'h00;
                    if (load_q) begin
                        rdata_d = (state_q == FIRST) ? al_rdata_first
                                                     : (rdata_q | al_rdata_second);
                    end
                    if (state_q == FIRST && al_split) begin
                        state_d     = SECOND;
                        bus_addr_d  = bus_addr_q + 32'd4;
                        bus_be_d    = al_be_second;
                        bus_wdata_d = al_wdata_second;
                    end else begin
                        to_done = 1'b1;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    to_done = 1'b1;
                    fault_d = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (to_done) begin
            state_d     = DONE;
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_addr_d  = 32'h0;
            bus_be_d    = 4'b0000;
            bus_wdata_d = 32'h0;
        end
    end

    // NOTE: reset is sampled on the clock edge only, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'h00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            fault_q     <= 1'b0;
            off_q       <= 2'b00;
            width_q     <= 2'b00;
            wdata_q     <= 32'h0;
            load_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            off_q       <= off_d;
            width_q     <= width_d;
            wdata_q     <= wdata_d;
            load_q      <= load_d;
        end
    end

    // Stall is combinational in IDLE so the CPU freezes in the request cycle.
    assign o_stall = i_rst_n & (idle ? request : (state_q != DONE));

    assign o_rdata     = rdata_q;
    assign o_fault     = fault_q;
    assign o_bus_req   = bus_req_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_be    = bus_be_q;
    assign o_bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a CPU driver plus a bus responder with a
// programmable ack delay, expected values hand-computed per scenario.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_load, i_write;
    logic [31:0] i_addr, i_wdata;
    logic [2:0]  i_funct3;
    logic [31:0] o_rdata;
    logic        o_stall, o_fault;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    int tests = 0;
    int fails = 0;

    int          n_beats;
    int          stall_cnt;
    logic [31:0] b_addr  [2];
    logic [3:0]  b_be    [2];
    logic [31:0] b_wdata [2];
    logic        b_we    [2];
    logic [31:0] done_rdata;
    logic        done_fault;
    logic        done_req;

    always #5 i_clk = ~i_clk;

    load_store_unit #(.TIMEOUT(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (i_load),
        .i_write     (i_write),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_funct3    (i_funct3),
        .o_rdata     (o_rdata),
        .o_stall     (o_stall),
        .o_fault     (o_fault),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_be    (o_bus_be),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata)
    );

    // Runs one CPU access to completion. delay = cycles the responder waits per
    // beat before acking (-1 = never). scramble perturbs address/data after acceptance.
    task automatic do_txn(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3, input int delay,
                          input logic [31:0] rd0, input logic [31:0] rd1, input logic scramble);
        int  waited;
        logic finished;
        n_beats  = 0;
        stall_cnt = 0;
        waited   = 0;
        finished = 1'b0;
        @(negedge i_clk);
        i_load = ld; i_write = st; i_addr = addr; i_wdata = wdata; i_funct3 = f3;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (!o_stall) begin
                done_rdata = o_rdata;
                done_fault = o_fault;
                done_req   = o_bus_req;
                finished   = 1'b1;
                break;
            end
            stall_cnt++;
            if (o_bus_req) begin
                if (waited == delay && n_beats < 2) begin
                    i_bus_ack   = 1'b1;
                    i_bus_rdata = (n_beats == 0) ? rd0 : rd1;
                    b_addr[n_beats]  = o_bus_addr;
                    b_be[n_beats]    = o_bus_be;
                    b_wdata[n_beats] = o_bus_wdata;
                    b_we[n_beats]    = o_bus_we;
                    n_beats++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
            @(negedge i_clk);
            i_bus_ack   = 1'b0;
            i_bus_rdata = 32'h0;
            if (scramble) begin
                i_addr = ~addr; i_wdata = ~wdata; i_funct3 = ~f3;
            end
            #1;
        end
        i_load = 1'b0; i_write = 1'b0; i_addr = addr; i_wdata = wdata; i_funct3 = f3;
        tests++;
        if (!finished) begin
            fails++;
            $display("FAIL txn_bound: stall still high after 40 cycles (addr %h), required completion", addr);
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0; i_load = 1'b1; i_write = 1'b0; i_addr = 32'h100;
        i_wdata = 32'h0; i_funct3 = 3'b010; i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk); #1;
        tests++; if (o_stall !== 1'b0)      begin fails++; $display("FAIL rst_stall: got %b want 0", o_stall); end
        tests++; if (o_bus_req !== 1'b0)    begin fails++; $display("FAIL rst_req: got %b want 0", o_bus_req); end
        tests++; if (o_bus_be !== 4'h0)     begin fails++; $display("FAIL rst_be: got %h want 0", o_bus_be); end
        tests++; if (o_bus_addr !== 32'h0)  begin fails++; $display("FAIL rst_addr: got %h want 0", o_bus_addr); end
        tests++; if (o_bus_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata: got %h want 0", o_bus_wdata); end
        tests++; if (o_rdata !== 32'h0)     begin fails++; $display("FAIL rst_rdata: got %h want 0", o_rdata); end
        tests++; if (o_fault !== 1'b0)      begin fails++; $display("FAIL rst_fault: got %b want 0", o_fault); end
        i_load = 1'b0;
        i_rst_n = 1'b1;
        @(negedge i_clk); #1;
        tests++; if (o_stall !== 1'b0 || o_bus_req !== 1'b0) begin
            fails++; $display("FAIL rst_release: stall %b req %b want 0 0", o_stall, o_bus_req);
        end
    endtask

    task automatic test_sw;
        do_txn(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 32'h0, 32'h0, 1'b0);
        tests++; if (n_beats !== 1)             begin fails++; $display("FAIL sw_beats: got %0d want 1", n_beats); end
        tests++; if (b_addr[0] !== 32'h100)     begin fails++; $display("FAIL sw_addr: got %h want 00000100", b_addr[0]); end
        tests++; if (b_be[0] !== 4'b1111)       begin fails++; $display("FAIL sw_be: got %b want 1111", b_be[0]); end
        tests++; if (b_wdata[0] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wdata: got %h want deadbeef", b_wdata[0]); end
        tests++; if (b_we[0] !== 1'b1)          begin fails++; $display("FAIL sw_we: got %b want 1", b_we[0]); end
        tests++; if (stall_cnt !== 2)           begin fails++; $display("FAIL sw_stall: got %0d want 2", stall_cnt); end
        tests++; if (done_fault !== 1'b0 || done_req !== 1'b0) begin
            fails++; $display("FAIL sw_done: fault %b req %b want 0 0", done_fault, done_req);
        end
    endtask

    // Address, data and width are scrambled after acceptance; the beat must not change.
    task automatic test_sb_sampled_once;
        do_txn(1'b0, 1'b1, 32'h203, 32'h000000AB, 3'b000, 1, 32'h0, 32'h0, 1'b1);
        tests++; if (n_beats !== 1)             begin fails++; $display("FAIL sb_beats: got %0d want 1", n_beats); end
        tests++; if (b_addr[0] !== 32'h200)     begin fails++; $display("FAIL sb_addr: got %h want 00000200", b_addr[0]); end
        tests++; if (b_be[0] !== 4'b1000)       begin fails++; $display("FAIL sb_be: got %b want 1000", b_be[0]); end
        tests++; if (b_wdata[0] !== 32'hAB000000) begin fails++; $display("FAIL sb_wdata: got %h want ab000000", b_wdata[0]); end
        tests++; if (stall_cnt !== 3)           begin fails++; $display("FAIL sb_stall: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_lw_split;
        do_txn(1'b1, 1'b0, 32'h102, 32'h0, 3'b010, 0, 32'h44332211, 32'h88776655, 1'b0);
        tests++; if (n_beats !== 2)             begin fails++; $display("FAIL lw_beats: got %0d want 2", n_beats); end
        tests++; if (b_addr[0] !== 32'h100 || b_be[0] !== 4'b1100) begin
            fails++; $display("FAIL lw_beat0: got %h/%b want 00000100/1100", b_addr[0], b_be[0]);
        end
        tests++; if (b_addr[1] !== 32'h104 || b_be[1] !== 4'b0011) begin
            fails++; $display("FAIL lw_beat1: got %h/%b want 00000104/0011", b_addr[1], b_be[1]);
        end
        tests++; if (b_we[0] !== 1'b0 || b_we[1] !== 1'b0) begin
            fails++; $display("FAIL lw_we: got %b%b want 00", b_we[0], b_we[1]);
        end
        tests++; if (done_rdata !== 32'h66554433) begin fails++; $display("FAIL lw_rdata: got %h want 66554433", done_rdata); end
        tests++; if (stall_cnt !== 3)           begin fails++; $display("FAIL lw_stall: got %0d want 3", stall_cnt); end
    endtask

    task automatic test_narrow_loads;
        do_txn(1'b1, 1'b0, 32'h101, 32'h0, 3'b100, 0, 32'h44332211, 32'h0, 1'b0);
        tests++; if (b_be[0] !== 4'b0010)       begin fails++; $display("FAIL lb_be: got %b want 0010", b_be[0]); end
        tests++; if (done_rdata !== 32'h00000022) begin fails++; $display("FAIL lb_rdata: got %h want 00000022", done_rdata); end
        do_txn(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 2, 32'h44332211, 32'h0, 1'b0);
        tests++; if (n_beats !== 1 || b_be[0] !== 4'b1100) begin
            fails++; $display("FAIL lh_beat: got %0d beats be %b want 1 beat be 1100", n_beats, b_be[0]);
        end
        tests++; if (done_rdata !== 32'h00004433) begin fails++; $display("FAIL lh_rdata: got %h want 00004433", done_rdata); end
        tests++; if (stall_cnt !== 4)           begin fails++; $display("FAIL lh_stall: got %0d want 4", stall_cnt); end
    endtask

    task automatic test_sh_wrap;
        do_txn(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00001234, 3'b001, 0, 32'h0, 32'h0, 1'b0);
        tests++; if (n_beats !== 2)             begin fails++; $display("FAIL shw_beats: got %0d want 2", n_beats); end
        tests++; if (b_addr[0] !== 32'hFFFFFFFC || b_be[0] !== 4'b1000 || b_wdata[0] !== 32'h34000000) begin
            fails++; $display("FAIL shw_beat0: got %h/%b/%h want fffffffc/1000/34000000", b_addr[0], b_be[0], b_wdata[0]);
        end
        tests++; if (b_addr[1] !== 32'h0 || b_be[1] !== 4'b0001 || b_wdata[1] !== 32'h00000012) begin
            fails++; $display("FAIL shw_beat1: got %h/%b/%h want 00000000/0001/00000012", b_addr[1], b_be[1], b_wdata[1]);
        end
    endtask

    task automatic test_illegal;
        do_txn(1'b1, 1'b0, 32'h0, 32'h0, 3'b011, 0, 32'h0, 32'h0, 1'b0);
        tests++; if (done_fault !== 1'b1)       begin fails++; $display("FAIL ill_width_fault: got %b want 1", done_fault); end
        tests++; if (n_beats !== 0 || stall_cnt !== 1) begin
            fails++; $display("FAIL ill_width_bus: beats %0d stall %0d want 0 1", n_beats, stall_cnt);
        end
        @(negedge i_clk); #1;
        tests++; if (o_fault !== 1'b0)          begin fails++; $display("FAIL ill_pulse: got %b want 0", o_fault); end
        do_txn(1'b1, 1'b1, 32'h10, 32'h0, 3'b010, 0, 32'h0, 32'h0, 1'b0);
        tests++; if (done_fault !== 1'b1 || n_beats !== 0) begin
            fails++; $display("FAIL ill_both: fault %b beats %0d want 1 0", done_fault, n_beats);
        end
    endtask

    task automatic test_timeout;
        do_txn(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, -1, 32'h0, 32'h0, 1'b0);
        tests++; if (done_fault !== 1'b1)       begin fails++; $display("FAIL to_fault: got %b want 1", done_fault); end
        tests++; if (done_rdata !== 32'h0)      begin fails++; $display("FAIL to_rdata: got %h want 0", done_rdata); end
        tests++; if (done_req !== 1'b0)         begin fails++; $display("FAIL to_req: got %b want 0", done_req); end
        tests++; if (stall_cnt < 5 || stall_cnt > 6) begin fails++; $display("FAIL to_stall: got %0d want 5..6", stall_cnt); end
        @(negedge i_clk); #1;
        tests++; if (o_fault !== 1'b0 || o_bus_req !== 1'b0) begin
            fails++; $display("FAIL to_after: fault %b req %b want 0 0", o_fault, o_bus_req);
        end
    endtask

    task automatic test_back_to_back;
        do_txn(1'b1, 1'b0, 32'h8, 32'h0, 3'b010, 0, 32'hCAFEF00D, 32'h0, 1'b0);
        tests++; if (done_rdata !== 32'hCAFEF00D || stall_cnt !== 2) begin
            fails++; $display("FAIL b2b_first: rdata %h stall %0d want cafef00d 2", done_rdata, stall_cnt);
        end
        do_txn(1'b1, 1'b0, 32'hB, 32'h0, 3'b000, 0, 32'h5A000000, 32'h0, 1'b0);
        tests++; if (done_rdata !== 32'h0000005A || b_addr[0] !== 32'h8) begin
            fails++; $display("FAIL b2b_second: rdata %h addr %h want 0000005a 00000008", done_rdata, b_addr[0]);
        end
    endtask

    task automatic test_stray_ack;
        @(negedge i_clk);
        i_bus_ack = 1'b1; i_bus_rdata = 32'hFFFFFFFF;
        repeat (2) @(negedge i_clk);
        #1;
        tests++; if (o_stall !== 1'b0 || o_bus_req !== 1'b0 || o_rdata !== 32'h0000005A) begin
            fails++; $display("FAIL stray_ack: stall %b req %b rdata %h want 0 0 0000005a", o_stall, o_bus_req, o_rdata);
        end
        i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
    endtask

    task automatic test_reset_mid;
        @(negedge i_clk);
        i_write = 1'b1; i_addr = 32'hFFFFFFFF; i_wdata = 32'h1234; i_funct3 = 3'b001;
        @(negedge i_clk); #1;
        tests++; if (o_bus_req !== 1'b1)        begin fails++; $display("FAIL rm_first: req %b want 1", o_bus_req); end
        i_bus_ack = 1'b1;
        @(negedge i_clk);
        i_bus_ack = 1'b0; #1;
        tests++; if (o_bus_req !== 1'b1 || o_bus_addr !== 32'h0) begin
            fails++; $display("FAIL rm_second: req %b addr %h want 1 00000000", o_bus_req, o_bus_addr);
        end
        i_rst_n = 1'b0; i_write = 1'b0;
        @(negedge i_clk); #1;
        tests++; if (o_bus_req !== 1'b0 || o_stall !== 1'b0 || o_bus_be !== 4'h0) begin
            fails++; $display("FAIL rm_abort: req %b stall %b be %b want 0 0 0000", o_bus_req, o_stall, o_bus_be);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk); #1;
        tests++; if (o_bus_req !== 1'b0 || o_stall !== 1'b0) begin
            fails++; $display("FAIL rm_idle: req %b stall %b want 0 0", o_bus_req, o_stall);
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb_sampled_once();
        test_lw_split();
        test_narrow_loads();
        test_sh_wrap();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_stray_ack();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: bus-ack wait limit per beat, in cycles (1..255).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset; synchronous, active-low.
REQ-004 i_load  input  1  CPU load request, held until the cycle o_stall is low.
REQ-005 i_write  input  1  CPU store request, held the same way.
REQ-006 i_addr  input  32  byte address (CPU ALU result).
REQ-007 i_wdata  input  32  store data, right-aligned.
REQ-008 i_funct3  input  3  instruction bits 14:12; bits 1:0 give width (00 byte, 01 half, 10 word).
REQ-009 o_rdata  output  32  load data, right-aligned, upper unused bytes zero (CPU sign-extends).
REQ-010 o_stall  output  1  CPU must hold PC and instruction while high.
REQ-011 o_fault  output  1  one-cycle pulse: illegal width, load+write both set, or timeout.
REQ-012 o_bus_req  output  1  registered word-bus request.
REQ-013 o_bus_we  output  1  1 = write beat.
REQ-014 o_bus_addr  output  32  word-aligned address, bits 1:0 always 0.
REQ-015 o_bus_be  output  4  byte enables, bit k = byte lane k.
REQ-016 o_bus_wdata  output  32  lane-positioned write data.
REQ-017 i_bus_ack  input  1  beat complete; read data valid on i_bus_rdata same cycle.
REQ-018 i_bus_rdata  input  32  read word.

Function
REQ-019 FSM states: IDLE, FIRST, SECOND, DONE.
REQ-020 IDLE: i_load|i_write -> o_stall high combinationally same cycle; next state FIRST, or DONE with fault if width 11 or both requests set (no bus activity).
REQ-021 Offset k = i_addr[1:0], n = 1/2/4 bytes; access splits into two beats when k+n > 4.
REQ-022 FIRST beat: addr = i_addr & ~3; be = lanes k..min(k+n,4)-1; wdata = i_wdata << 8k.
REQ-023 SECOND beat: addr = first addr + 4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); be = lanes 0..k+n-5; wdata = i_wdata >> 8(4-k).
REQ-024 o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata are registered, stable for the whole beat, asserted only in FIRST/SECOND.
REQ-025 Ack in FIRST -> SECOND if split, else DONE; ack in SECOND -> DONE; o_bus_req deasserts on the edge the ack is sampled.
REQ-026 Load assembly: first-beat lanes k.. -> o_rdata bytes 0..; second-beat lanes 0.. -> following bytes; latched at each ack.
REQ-027 DONE: o_stall low, o_rdata valid, o_fault pulses if flagged; unconditionally -> IDLE next cycle (the still-present request is not re-accepted).
REQ-028 Minimum latency: aligned access with immediate ack stalls 2 cycles, completes in the 3rd.
REQ-029 Per-beat 8-bit wait counter cleared on beat entry; reaching TIMEOUT without ack -> DONE with o_fault, o_rdata = 0, remaining beat skipped.
REQ-030 i_bus_ack outside FIRST/SECOND is ignored.
REQ-031 Request inputs are sampled on acceptance in IDLE; later changes before DONE are ignored.

Reset
REQ-032 i_rst_n low at an edge: state IDLE, o_bus_req/o_bus_we 0, o_bus_be 0, o_bus_addr/o_bus_wdata 0, o_rdata 0, o_fault 0, counter 0.
REQ-033 Reset mid-transaction aborts it; a half-completed split store is not rolled back.
REQ-034 o_stall is 0 during reset regardless of requests.

Structure
REQ-035 Package lsu_pkg holds the state enum, width enum (BYTE/HALF/WORD), and the TIMEOUT default.
REQ-036 Sub-module byte_lane_align (combinational) computes be, shifted wdata, and read-lane extraction for both beats.

Verification
REQ-037 SW 0xDEADBEEF @0x100, ack next cycle -> one beat, addr 0x100, be 1111, wdata 0xDEADBEEF; o_stall high 2 cycles.
REQ-038 SB 0x000000AB @0x203 -> addr 0x200, be 1000, wdata 0xAB000000.
REQ-039 LW @0x102, first beat rdata 0x44332211, second beat 0x88776655 -> beats @0x100 be 1100 and @0x104 be 0011; o_rdata 0x66554433.
REQ-040 SH 0x1234 @0xFFFFFFFF -> beat @0xFFFFFFFC be 1000 wdata 0x34000000, then @0x00000000 be 0001 wdata 0x00000012.
REQ-041 LW @0x40, ack never asserted, TIMEOUT=4 -> o_fault pulses in DONE, o_rdata 0, o_bus_req low afterwards.
REQ-042 i_rst_n low during SECOND of a split store -> next cycle IDLE, o_bus_req 0, o_stall 0.
